// File: rtl/counter_pkg.sv
// Shared types and helpers for the free-running counter slice.
// Default count width and its modular increment.
package counter_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

    function automatic cnt_t cnt_inc(input cnt_t v);
        return v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/modport_counter_rst_sync.sv
// Reset synchroniser: asserts asynchronously, releases after two clk edges.
// Active-low in and out.
module rst_sync (
    input  logic clk,
    input  logic arst_n,
    output logic sync_n
);

    logic meta_n;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            meta_n <= 1'b0;
            sync_n <= 1'b0;
        end else begin
            meta_n <= 1'b1;
            sync_n <= meta_n;
        end
    end

endmodule

// File: rtl/modport_counter.sv
// Free-running binary up-counter with a registered terminal-count flag.
// Reset asserts asynchronously and releases through rst_sync.
module modport_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_h,
    output logic [WIDTH-1:0] out,
    output logic             tc
);

    localparam logic [WIDTH-1:0] RST  = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONES = '1;

    logic             rst_n;
    logic [WIDTH-1:0] nxt;

    rst_sync u_rst_sync (
        .clk    (clk),
        .arst_n (rst_h),
        .sync_n (rst_n)
    );

    generate
        if (WIDTH == CNT_W_DEFAULT) begin : g_pkg_inc
            assign nxt = cnt_inc(out);
        end else begin : g_gen_inc
            assign nxt = out + WIDTH'(1);
        end
    endgenerate

    // tc is a flop fed from the next count so it never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= RST;
            tc  <= (RST == ONES);
        end else begin
            out <= nxt;
            tc  <= (nxt == ONES);
        end
    end

endmodule

// File: tb/tb_modport_counter.sv
// Directed bench for modport_counter at WIDTH=8/RESET_VAL=0 and WIDTH=4/RESET_VAL=10.
module tb_modport_counter;

    logic       clk;
    logic       rst_h;
    logic       rst4;
    logic [7:0] out;
    logic       tc;
    logic [3:0] out4;
    logic       tc4;

    int total;
    int bad;
    int unsigned exp;

    modport_counter #(.WIDTH(8), .RESET_VAL(0)) dut (
        .clk   (clk),
        .rst_h (rst_h),
        .out   (out),
        .tc    (tc)
    );

    modport_counter #(.WIDTH(4), .RESET_VAL(10)) dut4 (
        .clk   (clk),
        .rst_h (rst4),
        .out   (out4),
        .tc    (tc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got,
                       input int unsigned want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // After release, out holds 0 until the sync lets it step to 1.
    task automatic wait_start();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out == 8'd1) break;
            chk("pre_start", out, 0);
        end
        chk("start", out, 1);
        exp = 1;
    endtask

    task automatic step_chk(input string tag);
        @(negedge clk);
        exp = (exp + 1) & 8'hff;
        chk(tag, out, exp);
        chk({tag, "_tc"}, tc, (exp == 255) ? 1 : 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_h = 1'b0;
        rst4  = 1'b0;

        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_out", out, 0);
            chk("rst_tc", tc, 0);
            chk("rst4_out", out4, 10);
            chk("rst4_tc", tc4, 0);
        end

        #2 rst_h = 1'b1;
        wait_start();
        chk("start_tc", tc, 0);

        // 300 clocks out of reset: covers 255 with tc and the wrap to 0.
        for (int i = 0; i < 300; i++) step_chk("run");

        while (exp != 100) step_chk("to100");

        #2 rst_h = 1'b0;
        #1;
        chk("mid_rst_out", out, 0);
        chk("mid_rst_tc", tc, 0);
        repeat (2) begin
            @(negedge clk);
            chk("mid_hold", out, 0);
        end

        #2 rst_h = 1'b1;
        wait_start();
        for (int i = 0; i < 5; i++) step_chk("resume");

        while (exp != 255) step_chk("to255");
        chk("at255_tc", tc, 1);

        #2 rst_h = 1'b0;
        #1;
        chk("rst255_out", out, 0);
        chk("rst255_tc", tc, 0);
        repeat (3) begin
            @(negedge clk);
            chk("post255_out", out, 0);
            chk("post255_tc", tc, 0);
        end
        #2 rst_h = 1'b1;
        wait_start();

        // WIDTH=4, RESET_VAL=10: 11..15 (tc at 15), 0, ..., back to 10.
        #2 rst4 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out4 != 4'd10) break;
        end
        chk("w4_start", out4, 11);
        exp = 11;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            exp = (exp + 1) & 4'hf;
            chk("w4_seq", out4, exp);
            chk("w4_tc", tc4, (exp == 15) ? 1 : 0);
        end
        chk("w4_back10", out4, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
